stream_sink_mc: RTL and testbench

Multi-channel, self-checking stream sink for simulation benches. It terminates CH_NB independent vld/rdy streams and generates per-channel back-pressure from a seeded LFSR with programmable throughput. It counts accepted samples per channel and checks each sample against an internally generated incrementing reference, capturing the first mismatch. It replaces a chain of single-channel file-based sinks wherever the DUT emits several parallel streams whose expected content is a counter pattern.

---
 rtl/stream_sink_mc.sv | 182 ++++++++++++++++++
 tb/tb_stream_sink_mc.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_sink_mc.sv
// Multi-channel vld/rdy stream sink: LFSR-driven back-pressure, per-channel sample
// counting and incrementing-pattern data check with first-mismatch capture.
module stream_sink_mc #(
    parameter int          CH_NB    = 4,
    parameter int          DATA_W   = 16,
    parameter int          THR_W    = 8,
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter int          KEEP_RDY = 0,
    localparam int         CH_W     = (CH_NB > 1) ? $clog2(CH_NB) : 1
) (
    input  logic                    clk,
    input  logic                    s_rst,
    input  logic [CH_NB*DATA_W-1:0] in_data,
    input  logic [CH_NB-1:0]        in_vld,
    output logic [CH_NB-1:0]        in_rdy,
    input  logic                    start,
    input  logic                    stop,
    input  logic [31:0]             count,
    input  logic [THR_W-1:0]        throughput,
    input  logic                    chk_en,
    input  logic [DATA_W-1:0]       ref_base,
    output logic [CH_NB*32-1:0]     sample_cnt,
    output logic                    done,
    output logic                    error,
    output logic [CH_W-1:0]         err_ch,
    output logic [DATA_W-1:0]       err_data,
    output logic [DATA_W-1:0]       err_exp
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    localparam logic [15:0]      LFSR_TAPS = 16'hB400;  // x^16+x^14+x^13+x^11+1
    localparam logic [THR_W-1:0] THR_MAX   = '1;

    state_t            state_q [CH_NB];
    state_t            state_d [CH_NB];
    logic [15:0]       lfsr_q  [CH_NB];
    logic [15:0]       lfsr_d  [CH_NB];
    logic [31:0]       cnt_q   [CH_NB];
    logic [31:0]       cnt_d   [CH_NB];
    logic [DATA_W-1:0] exp_q   [CH_NB];
    logic [DATA_W-1:0] exp_d   [CH_NB];

    logic [CH_NB-1:0]  rdy_ctrl_q, rdy_ctrl_d;
    logic [31:0]       count_q, count_d;
    logic              chk_en_q, chk_en_d;
    logic              error_q, error_d;
    logic [CH_W-1:0]   err_ch_q, err_ch_d;
    logic [DATA_W-1:0] err_data_q, err_data_d;
    logic [DATA_W-1:0] err_exp_q, err_exp_d;

    logic [CH_NB-1:0]  xfer, mismatch, rdy_eval;
    logic              do_start;

    assign do_start = start & ~stop;

    // Reset masks ready combinationally so no transfer can complete on a reset edge.
    always_comb begin
        in_rdy   = '0;
        xfer     = '0;
        mismatch = '0;
        for (int c = 0; c < CH_NB; c++) begin
            in_rdy[c]   = rdy_ctrl_q[c] & (state_q[c] == ST_RUN) & ~s_rst;
            xfer[c]     = in_vld[c] & in_rdy[c];
            mismatch[c] = xfer[c] & chk_en_q & (in_data[c*DATA_W +: DATA_W] != exp_q[c]);
        end
    end

    always_comb begin
        rdy_eval   = '0;
        rdy_ctrl_d = rdy_ctrl_q;
        for (int c = 0; c < CH_NB; c++) begin
            lfsr_d[c] = (lfsr_q[c] >> 1) ^ (lfsr_q[c][0] ? LFSR_TAPS : 16'h0000);
            if (throughput == THR_MAX)
                rdy_eval[c] = 1'b1;
            else if (throughput == '0)
                rdy_eval[c] = lfsr_q[c][0];
            else
                rdy_eval[c] = (lfsr_q[c][THR_W-1:0] < throughput);
            // A held ready is only released by the transfer it was waiting for.
            if (KEEP_RDY == 0 || xfer[c] || !rdy_ctrl_q[c])
                rdy_ctrl_d[c] = rdy_eval[c];
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        for (int c = 0; c < CH_NB; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            exp_d[c]   = exp_q[c];
            if (stop) begin
                state_d[c] = ST_IDLE;
            end else if (start) begin
                state_d[c] = ST_RUN;
                cnt_d[c]   = '0;
                exp_d[c]   = ref_base + DATA_W'(c);
            end else if (xfer[c]) begin
                cnt_d[c] = (cnt_q[c] == 32'hFFFF_FFFF) ? cnt_q[c] : cnt_q[c] + 32'd1;
                exp_d[c] = exp_q[c] + DATA_W'(1);
                if (count_q != 32'd0 && cnt_d[c] == count_q)
                    state_d[c] = ST_DONE;
            end
        end
    end

    always_comb begin
        count_d    = count_q;
        chk_en_d   = chk_en_q;
        error_d    = error_q;
        err_ch_d   = err_ch_q;
        err_data_d = err_data_q;
        err_exp_d  = err_exp_q;
        if (do_start) begin
            count_d    = count;
            chk_en_d   = chk_en;
            error_d    = 1'b0;
            err_ch_d   = '0;
            err_data_d = '0;
            err_exp_d  = '0;
        end else if (!stop && !error_q && (|mismatch)) begin
            error_d = 1'b1;
            // Descending scan so the lowest mismatching channel is the one kept.
            for (int c = CH_NB - 1; c >= 0; c--) begin
                if (mismatch[c]) begin
                    err_ch_d   = CH_W'(c);
                    err_data_d = in_data[c*DATA_W +: DATA_W];
                    err_exp_d  = exp_q[c];
                end
            end
        end
    end

    always_comb begin
        sample_cnt = '0;
        done       = 1'b1;
        for (int c = 0; c < CH_NB; c++) begin
            sample_cnt[c*32 +: 32] = cnt_q[c];
            done                   = done & (state_q[c] == ST_DONE);
        end
    end

    assign error    = error_q;
    assign err_ch   = err_ch_q;
    assign err_data = err_data_q;
    assign err_exp  = err_exp_q;

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (s_rst) begin
            // NOTE: the per-channel arrays are plain flops, not RAM, so they are reset like any register.
            for (int c = 0; c < CH_NB; c++) begin
                state_q[c] <= ST_IDLE;
                lfsr_q[c]  <= SEED ^ 16'(c + 1);
                cnt_q[c]   <= '0;
                exp_q[c]   <= '0;
            end
            rdy_ctrl_q <= '0;
            count_q    <= '0;
            chk_en_q   <= 1'b0;
            error_q    <= 1'b0;
            err_ch_q   <= '0;
            err_data_q <= '0;
            err_exp_q  <= '0;
        end else begin
            for (int c = 0; c < CH_NB; c++) begin
                state_q[c] <= state_d[c];
                lfsr_q[c]  <= lfsr_d[c];
                cnt_q[c]   <= cnt_d[c];
                exp_q[c]   <= exp_d[c];
            end
            rdy_ctrl_q <= rdy_ctrl_d;
            count_q    <= count_d;
            chk_en_q   <= chk_en_d;
            error_q    <= error_d;
            err_ch_q   <= err_ch_d;
            err_data_q <= err_data_d;
            err_exp_q  <= err_exp_d;
        end
    end

endmodule

// File: tb/tb_stream_sink_mc.sv
// Directed bench for stream_sink_mc: a 4-channel instance (KEEP_RDY=0) and a
// 1-channel instance (KEEP_RDY=1) sharing the control inputs.
module tb_stream_sink_mc;

    localparam int CH = 4;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            s_rst;
    logic [CH*DW-1:0] in_data;
    logic [CH-1:0]   in_vld;
    logic [CH-1:0]   in_rdy;
    logic            start, stop;
    logic [31:0]     count;
    logic [7:0]      throughput;
    logic            chk_en;
    logic [DW-1:0]   ref_base;
    logic [CH*32-1:0] sample_cnt;
    logic            done, error;
    logic [1:0]      err_ch;
    logic [DW-1:0]   err_data, err_exp;

    logic [DW-1:0]   in_data_k;
    logic            in_vld_k, in_rdy_k;
    logic [31:0]     sample_cnt_k;
    logic            done_k, error_k;
    logic [0:0]      err_ch_k;
    logic [DW-1:0]   err_data_k, err_exp_k;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stream_sink_mc #(.CH_NB(CH), .DATA_W(DW), .THR_W(8), .SEED(16'hACE1), .KEEP_RDY(0)) dut (
        .clk(clk), .s_rst(s_rst), .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
        .start(start), .stop(stop), .count(count), .throughput(throughput), .chk_en(chk_en),
        .ref_base(ref_base), .sample_cnt(sample_cnt), .done(done), .error(error),
        .err_ch(err_ch), .err_data(err_data), .err_exp(err_exp)
    );

    stream_sink_mc #(.CH_NB(1), .DATA_W(DW), .THR_W(8), .SEED(16'hACE1), .KEEP_RDY(1)) dut_k (
        .clk(clk), .s_rst(s_rst), .in_data(in_data_k), .in_vld(in_vld_k), .in_rdy(in_rdy_k),
        .start(start), .stop(stop), .count(count), .throughput(throughput), .chk_en(chk_en),
        .ref_base(ref_base), .sample_cnt(sample_cnt_k), .done(done_k), .error(error_k),
        .err_ch(err_ch_k), .err_data(err_data_k), .err_exp(err_exp_k)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cnts(input string tag, input int exp);
        for (int c = 0; c < CH; c++)
            check($sformatf("%s_cnt_ch%0d", tag, c), 64'(sample_cnt[c*32 +: 32]), 64'(exp));
    endtask

    // Full-rate burst of n samples per channel; channel c carries base+c+k, optionally
    // with up to two samples replaced by 0xFFFF.
    task automatic burst(input string tag, input logic [15:0] base, input int n,
                         input int bad_ch, input int bad_k, input int bad2_ch, input int bad2_k);
        logic [15:0] d;
        ref_base   = base;
        count      = 32'(n);
        chk_en     = 1'b1;
        throughput = 8'hFF;
        in_vld     = '1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            check_cnts(tag, k);
            check({tag, "_rdy"}, 64'(in_rdy), 64'hF);
            check({tag, "_done"}, 64'(done), 64'd0);
            check({tag, "_err"}, 64'((bad_ch >= 0 && k > bad_k) ? 1 : 0), 64'(error));
            for (int c = 0; c < CH; c++) begin
                d = base + 16'(c) + 16'(k);
                if ((c == bad_ch && k == bad_k) || (c == bad2_ch && k == bad2_k))
                    d = 16'hFFFF;
                in_data[c*DW +: DW] = d;
            end
            @(negedge clk);
        end
        check_cnts({tag, "_end"}, n);
        check({tag, "_end_done"}, 64'(done), 64'd1);
        check({tag, "_end_rdy"}, 64'(in_rdy), 64'd0);
    endtask

    initial begin
        s_rst      = 1'b1;
        in_data    = '0;
        in_vld     = '0;
        start      = 1'b0;
        stop       = 1'b0;
        count      = '0;
        throughput = 8'hFF;
        chk_en     = 1'b0;
        ref_base   = '0;
        in_data_k  = '0;
        in_vld_k   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_rdy", 64'(in_rdy), 64'd0);
        check_cnts("rst", 0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_err_ch", 64'(err_ch), 64'd0);
        check("rst_err_data", 64'(err_data), 64'd0);
        check("rst_err_exp", 64'(err_exp), 64'd0);
        s_rst = 1'b0;

        // Clean 8-sample burst
        burst("clean", 16'h0010, 8, -1, -1, -1, -1);
        check("clean_error", 64'(error), 64'd0);

        // Corrupted ch2 sample 5, later ch0 sample 7 must not overwrite capture
        burst("corrupt", 16'h0010, 8, 2, 5, 0, 7);
        check("corrupt_error", 64'(error), 64'd1);
        check("corrupt_err_ch", 64'(err_ch), 64'd2);
        check("corrupt_err_data", 64'(err_data), 64'hFFFF);
        check("corrupt_err_exp", 64'(err_exp), 64'h0017);

        // Wrap of the expected value
        burst("wrap", 16'hFFFE, 4, -1, -1, -1, -1);
        check("wrap_error", 64'(error), 64'd0);

        // Throughput 64/256 over 8192 cycles, unlimited count
        throughput = 8'd64;
        count      = 32'd0;
        chk_en     = 1'b0;
        in_vld     = '1;
        in_vld_k   = 1'b0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8192) @(negedge clk);
        for (int c = 0; c < CH; c++) begin
            int unsigned v;
            v = sample_cnt[c*32 +: 32];
            check($sformatf("thr_ch%0d_cnt%0d_in_range", c, v), 64'((v >= 1802 && v <= 2294) ? 1 : 0), 64'd1);
        end
        check("thr_done", 64'(done), 64'd0);
        check("thr_error", 64'(error), 64'd0);

        // KEEP_RDY=1 holds ready with no valid
        check("keep_rdy_up", 64'(in_rdy_k), 64'd1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check($sformatf("keep_hold_%0d", i), 64'(in_rdy_k), 64'd1);
        end
        check("keep_cnt0", 64'(sample_cnt_k), 64'd0);
        in_vld_k = 1'b1;
        @(negedge clk);
        in_vld_k = 1'b0;
        check("keep_cnt1", 64'(sample_cnt_k), 64'd1);

        // Mid-run mismatch, then stop+start in the same cycle
        throughput = 8'hFF;
        count      = 32'd0;
        chk_en     = 1'b1;
        ref_base   = 16'h0100;
        in_vld     = '1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < CH; c++)
                in_data[c*DW +: DW] = (c == 1 && k == 2) ? 16'hDEAD : 16'h0100 + 16'(c) + 16'(k);
            @(negedge clk);
        end
        check_cnts("mid", 4);
        check("mid_error", 64'(error), 64'd1);
        check("mid_err_ch", 64'(err_ch), 64'd1);
        check("mid_err_data", 64'(err_data), 64'hDEAD);
        check("mid_err_exp", 64'(err_exp), 64'h0103);
        in_vld = '0;
        start  = 1'b1;
        stop   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check("ss_rdy", 64'(in_rdy), 64'd0);
        check("ss_done", 64'(done), 64'd0);
        check_cnts("ss", 4);
        check("ss_error", 64'(error), 64'd1);
        @(negedge clk);
        check("ss_idle_rdy", 64'(in_rdy), 64'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_cnts("restart", 0);
        check("restart_error", 64'(error), 64'd0);
        check("restart_rdy", 64'(in_rdy), 64'hF);

        // Mismatch on ch3, then synchronous reset during an active transfer
        in_vld = '1;
        for (int c = 0; c < CH; c++)
            in_data[c*DW +: DW] = (c == 3) ? 16'h0BAD : 16'h0100 + 16'(c);
        @(negedge clk);
        check_cnts("pre_rst", 1);
        check("pre_rst_error", 64'(error), 64'd1);
        check("pre_rst_err_ch", 64'(err_ch), 64'd3);
        for (int c = 0; c < CH; c++)
            in_data[c*DW +: DW] = 16'h0101 + 16'(c);
        s_rst = 1'b1;
        #1;
        check("srst_rdy_mask", 64'(in_rdy), 64'd0);
        @(negedge clk);
        s_rst = 1'b0;
        check_cnts("post_rst", 0);
        check("post_rst_rdy", 64'(in_rdy), 64'd0);
        check("post_rst_done", 64'(done), 64'd0);
        check("post_rst_error", 64'(error), 64'd0);
        check("post_rst_err_ch", 64'(err_ch), 64'd0);
        check("post_rst_err_data", 64'(err_data), 64'd0);
        check("post_rst_err_exp", 64'(err_exp), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
